// File: rtl/adc_frame_capture.sv
// ADC frame capture: level-crossing trigger, N-sample frame into block RAM, rd_en/rd_valid readout.
// Optional build macro ADC_DECIMATE_EN stores only every DEC-th sample after the trigger.
module adc_frame_capture #(
    parameter int DW = 8,
    parameter int AW = 10
`ifdef ADC_DECIMATE_EN
    , parameter int DEC = 4
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [DW-1:0] addata,
    input  logic          arm,
    input  logic          abort,
    input  logic [DW-1:0] trig_level,
    input  logic          trig_rising,
    output logic          busy,
    output logic          done,
    input  logic          rd_en,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_last
);
    localparam int N = 1 << AW;

    typedef enum logic [1:0] {IDLE, WAIT_TRIG, CAPTURE, DONE} state_t;

    state_t        state;
    logic [DW-1:0] s0, s1;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DW-1:0] mem [N];

    logic          trig_hit, wr_en, rd_fire;
    logic [AW-1:0] wr_addr;

`ifdef ADC_DECIMATE_EN
    localparam int DCW = $clog2(DEC);
    logic [DCW-1:0] dec_cnt;
    logic           full;
    wire            cap_wr = (dec_cnt == '0);
`else
    wire            cap_wr = 1'b1;
`endif

    // s0 is the newest sample, s1 the one before it
    assign trig_hit = trig_rising ? (s1 < trig_level) && (s0 >= trig_level)
                                  : (s1 > trig_level) && (s0 <= trig_level);

    assign wr_en   = !abort && (((state == WAIT_TRIG) && trig_hit) ||
                                ((state == CAPTURE) && cap_wr));
    assign wr_addr = (state == WAIT_TRIG) ? '0 : wr_ptr;
    assign rd_fire = (state == DONE) && rd_en && !arm && !abort;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= s0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            s0       <= '0;
            s1       <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            rd_data  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
`ifdef ADC_DECIMATE_EN
            dec_cnt  <= '0;
            full     <= 1'b0;
`endif
        end else begin
            s0       <= addata;
            s1       <= s0;
            rd_valid <= rd_fire;
            rd_last  <= rd_fire && (&rd_ptr);
            if (rd_fire) rd_data <= mem[rd_ptr];

            if (abort) begin
                state  <= IDLE;
                wr_ptr <= '0;
                rd_ptr <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    IDLE: if (arm) begin
                        state  <= WAIT_TRIG;
                        busy   <= 1'b1;
                        wr_ptr <= '0;
                        rd_ptr <= '0;
                    end
                    WAIT_TRIG: if (trig_hit) begin
                        state  <= CAPTURE;
                        wr_ptr <= AW'(1);
`ifdef ADC_DECIMATE_EN
                        dec_cnt <= DCW'(1);
                        full    <= 1'b0;
`endif
                    end
                    CAPTURE: begin
`ifdef ADC_DECIMATE_EN
                        // stay in CAPTURE until the last decimation slot so the frame spans N*DEC cycles
                        dec_cnt <= dec_cnt + DCW'(1);
                        if (cap_wr) begin
                            wr_ptr <= wr_ptr + AW'(1);
                            if (&wr_ptr) full <= 1'b1;
                        end
                        if (full && dec_cnt == DCW'(DEC - 1)) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`else
                        wr_ptr <= wr_ptr + AW'(1);
                        if (&wr_ptr) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
`endif
                    end
                    DONE: begin
                        if (arm) begin
                            state  <= WAIT_TRIG;
                            busy   <= 1'b1;
                            done   <= 1'b0;
                            wr_ptr <= '0;
                            rd_ptr <= '0;
                        end else if (rd_en) begin
                            rd_ptr <= rd_ptr + AW'(1);
                            if (&rd_ptr) begin
                                state <= IDLE;
                                done  <= 1'b0;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule
